// File: rtl/quad_sched.sv
// rtl/quad_sched.sv - two-requester Horner quadratic evaluator sharing one 16-bit multiplier
module quad_sched (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic [7:0]  x0,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic [15:0] c0,
    input  logic        req1,
    input  logic [7:0]  x1,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    input  logic [15:0] c1,
    output logic        grant0,
    output logic        grant1,
    output logic        ready,
    output logic        valid,
    output logic [15:0] result,
    output logic        owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC1 = 2'd1,
        MAC2 = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  x_q;
    logic [15:0] a_q, b_q, c_q;
    logic [15:0] acc_q, acc_d;
    logic [15:0] result_q;
    logic        owner_q;
    logic        sel_q;
    logic        last_q;
    logic        win;
    logic        any_req;
    logic [15:0] x_ext;
    logic [15:0] mul_a;
    logic [15:0] prod;
    logic [15:0] addend;

    // Round-robin pick: on a tie the requester not granted last wins
    always_comb begin
        any_req = req0 | req1;
        win     = 1'b0;
        if (req0 && req1) begin
            win = ~last_q;
        end else if (req1) begin
            win = 1'b1;
        end
    end

    // Shared multiply-add: MAC1 computes a*x+b, MAC2 computes acc*x+c (low 16 bits kept)
    always_comb begin
        x_ext  = {{8{x_q[7]}}, x_q};
        mul_a  = (state_q == MAC1) ? a_q : acc_q;
        addend = (state_q == MAC1) ? b_q : c_q;
        prod   = mul_a * x_ext;
        acc_d  = prod + addend;
    end

    // Next-state logic; arbitration only ever happens from IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = MAC1;
            MAC1:    state_d = MAC2;
            MAC2:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, operand capture, accumulator and registered result
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            x_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            owner_q  <= 1'b0;
            sel_q    <= 1'b0;
            last_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        sel_q  <= win;
                        last_q <= win;
                        x_q    <= win ? x1 : x0;
                        a_q    <= win ? a1 : a0;
                        b_q    <= win ? b1 : b0;
                        c_q    <= win ? c1 : c0;
                    end
                end
                MAC1: begin
                    acc_q <= acc_d;
                end
                MAC2: begin
                    acc_q    <= acc_d;
                    result_q <= acc_d;
                    owner_q  <= sel_q;
                end
                default: begin
                end
            endcase
        end
    end

    assign grant0 = (state_q == MAC1) && !sel_q;
    assign grant1 = (state_q == MAC1) &&  sel_q;
    assign ready  = (state_q == IDLE);
    assign valid  = (state_q == DONE);
    assign result = result_q;
    assign owner  = owner_q;

endmodule

// File: tb/tb_quad_sched.sv
// tb/tb_quad_sched.sv - scoreboard bench for quad_sched
module tb_quad_sched;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [7:0]  x0, x1;
    logic [15:0] a0, b0, c0, a1, b1, c1;
    logic        grant0, grant1, ready, valid, owner;
    logic [15:0] result;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int valid_cyc = -100;
    logic [16:0] sb[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    quad_sched dut (
        .clock  (clock),
        .reset  (reset),
        .req0   (req0),
        .x0     (x0),
        .a0     (a0),
        .b0     (b0),
        .c0     (c0),
        .req1   (req1),
        .x1     (x1),
        .a1     (a1),
        .b1     (b1),
        .c1     (c1),
        .grant0 (grant0),
        .grant1 (grant1),
        .ready  (ready),
        .valid  (valid),
        .result (result),
        .owner  (owner)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Scoreboard: every valid pops the oldest expected {owner, result}
    always @(negedge clock) begin
        logic [16:0] e;
        if (valid === 1'b1) begin
            valid_cyc = cyc;
            if (sb.size() == 0) begin
                check_val("unexpected_valid", valid, 0);
            end else begin
                e = sb.pop_front();
                check_val("result", result, e[15:0]);
                check_val("owner", owner, e[16]);
            end
        end
        if (grant0 === 1'b1 && grant1 === 1'b1) check_val("grant_excl", grant1, 0);
    end

    task automatic wait_grant(output int who, output int at);
        who = -1;
        at  = cyc;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (grant0 === 1'b1 || grant1 === 1'b1) begin
                who = (grant1 === 1'b1) ? 1 : 0;
                at  = cyc;
                return;
            end
        end
        check_val("grant_timeout", who, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clock);
        check_val("drain_empty", sb.size(), 0);
        @(negedge clock);
    endtask

    task automatic run_single(input logic [7:0] x, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] exp);
        int t0, g, who, nlow;
        @(posedge clock); #1;
        x0 = x; a0 = a; b0 = b; c0 = c;
        req0 = 1'b1;
        t0 = cyc;
        sb.push_back({1'b0, exp});
        wait_grant(who, g);
        check_val("single_who", who, 0);
        check_val("grant_latency", g - t0, 1);
        req0 = 1'b0;
        nlow = 1;
        @(negedge clock);
        check_val("grant_pulse", grant0, 0);
        while (ready !== 1'b1 && nlow < 10) begin
            nlow++;
            @(negedge clock);
        end
        check_val("busy_cycles", nlow, 3);
        check_val("valid_latency", valid_cyc - g, 2);
        drain();
    endtask

    initial begin
        int who, g, prev, g0, g1;
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int who, g, prev, g0, g1;
        reset = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        x0 = 8'd3; a0 = 16'd2; b0 = -16'sd5; c0 = 16'd7;
        x1 = -8'sd4; a1 = 16'd1; b1 = 16'd1; c1 = 16'd1;

        // Reset held two cycles with both requests up
        for (int i = 0; i < 2; i++) begin
            @(posedge clock);
            @(negedge clock);
            check_val("rst_ready", ready, 1);
            check_val("rst_valid", valid, 0);
            check_val("rst_grant0", grant0, 0);
            check_val("rst_grant1", grant1, 0);
            check_val("rst_result", result, 0);
            check_val("rst_owner", owner, 0);
        end
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;

        // Single request: 2*9 - 15 + 7 = 10
        run_single(8'd3, 16'd2, -16'sd5, 16'd7, 16'd10);

        // Re-reset so the tie starts from the reset pointer
        @(posedge clock); #1; reset = 1'b0;
        @(posedge clock); #1; reset = 1'b1;
        x0 = 8'd3; a0 = 16'd2; b0 = -16'sd5; c0 = 16'd7;
        x1 = -8'sd4; a1 = 16'd1; b1 = 16'd1; c1 = 16'd1;
        sb.push_back({1'b0, 16'd10});
        sb.push_back({1'b1, 16'd13});
        sb.push_back({1'b0, 16'd10});
        sb.push_back({1'b1, 16'd13});
        req0 = 1'b1; req1 = 1'b1;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_grant(who, g);
            check_val("tie_order", who, k % 2);
            if (k > 0) check_val("tie_spacing", g - prev, 4);
            prev = g;
        end
        req0 = 1'b0; req1 = 1'b0;
        drain();

        // Wrap-around
        run_single(8'd100, 16'd100, 16'd0, 16'd0, 16'h4240);
        run_single(-8'sd128, 16'd1, 16'd0, 16'd0, 16'h4000);

        // Reset during MAC2 of a requester-0 job, then tie restarts at requester 0
        @(posedge clock); #1;
        x0 = 8'd3; a0 = 16'd2; b0 = -16'sd5; c0 = 16'd7;
        req0 = 1'b1;
        wait_grant(who, g);
        check_val("abort_grant", who, 0);
        req1 = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_val("abort_valid", valid, 0);
        check_val("abort_ready", ready, 1);
        check_val("abort_result", result, 0);
        check_val("abort_owner", owner, 0);
        check_val("abort_grant1", grant1, 0);
        reset = 1'b1;
        sb.push_back({1'b0, 16'd10});
        wait_grant(who, g);
        check_val("regrant_who", who, 0);
        req0 = 1'b0; req1 = 1'b0;
        drain();

        // Request raised while busy waits for IDLE
        @(posedge clock); #1;
        req0 = 1'b1;
        sb.push_back({1'b0, 16'd10});
        wait_grant(who, g0);
        check_val("busy_first_who", who, 0);
        req0 = 1'b0;
        req1 = 1'b1;
        sb.push_back({1'b1, 16'd13});
        wait_grant(who, g1);
        check_val("busy_second_who", who, 1);
        check_val("busy_regrant_gap", g1 - g0, 4);
        check_val("busy_after_valid", g1 - valid_cyc, 2);
        req1 = 1'b0;
        drain();

        check_val("sb_final_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
